// File: rtl/result_pkg.sv
// Constants and readback FSM encoding shared by the result memory writer and reader.
package result_pkg;
   localparam logic [31:0] RESULT_STRIDE           = 32'h0000_060E;
   localparam int          RESULT_NUM_SLOTS        = 16;
   localparam int          RESULT_WORDS_PER_RECORD = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      SEND = 2'd2
   } rb_state_t;
endpackage

// File: rtl/result_pending_counter.sv
// Records written-but-unread: up/down, saturates at NUM_SLOTS, sticky overflow.
// One-cycle update latency; a simultaneous inc and dec leaves the count unchanged.
module result_pending_counter import result_pkg::*; #(
   parameter int NUM_SLOTS = RESULT_NUM_SLOTS,
   parameter int CW        = $clog2(NUM_SLOTS + 1)
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          inc,
   input  logic          dec,
   output logic [CW-1:0] count,
   output logic          overflow
);
   localparam logic [CW-1:0] FULL = CW'(NUM_SLOTS);

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         count    <= '0;
         overflow <= 1'b0;
      end else if (inc && !dec) begin
         if (count == FULL)
            overflow <= 1'b1;
         else
            count <= count + CW'(1);
      end else if (dec && !inc && count != '0) begin
         count <= count - CW'(1);
      end
   end
endmodule

// File: rtl/result_address_readback.sv
// Walks the writer's slot sequence and streams each record word-by-word to the host.
// Per word: 1 request cycle + 1 send cycle minimum; mem_addr/out_data hold while stalled.
module result_address_readback import result_pkg::*; #(
   parameter logic [31:0] STRIDE           = RESULT_STRIDE,
   parameter int          WORDS_PER_RECORD = RESULT_WORDS_PER_RECORD,
   parameter int          NUM_SLOTS        = RESULT_NUM_SLOTS,
   localparam int         PW               = $clog2(NUM_SLOTS + 1)
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          record_written,
   output logic          mem_read,
   output logic [31:0]   mem_addr,
   input  logic [31:0]   mem_rdata,
   input  logic          mem_rvalid,
   output logic [31:0]   out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_last,
   output logic [PW-1:0] pending,
   output logic          overflow
);
   localparam int            IW        = (WORDS_PER_RECORD > 1) ? $clog2(WORDS_PER_RECORD) : 1;
   localparam logic [IW-1:0] LAST_WORD = IW'(WORDS_PER_RECORD - 1);
   localparam logic [PW-1:0] LAST_SLOT = PW'(NUM_SLOTS);

   rb_state_t     state;
   logic [PW-1:0] slot;
   logic [31:0]   slot_base;
   logic [IW-1:0] word;
   logic          consume;

   assign consume = (state == SEND) && out_ready && out_last;

   result_pending_counter #(
      .NUM_SLOTS (NUM_SLOTS)
   ) u_pending (
      .clk      (clk),
      .n_rst    (n_rst),
      .inc      (record_written),
      .dec      (consume),
      .count    (pending),
      .overflow (overflow)
   );

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state     <= IDLE;
         slot      <= '0;
         slot_base <= '0;
         word      <= '0;
         mem_read  <= 1'b0;
         mem_addr  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pending != '0) begin
                  word     <= '0;
                  mem_read <= 1'b1;
                  state    <= REQ;
                  // slot 0 only exists out of reset; the ring is 1..NUM_SLOTS
                  if (slot == LAST_SLOT) begin
                     slot      <= PW'(1);
                     slot_base <= STRIDE;
                     mem_addr  <= STRIDE;
                  end else begin
                     slot      <= slot + PW'(1);
                     slot_base <= slot_base + STRIDE;
                     mem_addr  <= slot_base + STRIDE;
                  end
               end
            end
            REQ: begin
               if (mem_rvalid) begin
                  mem_read  <= 1'b0;
                  out_data  <= mem_rdata;
                  out_valid <= 1'b1;
                  out_last  <= (word == LAST_WORD);
                  state     <= SEND;
               end
            end
            SEND: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  if (out_last) begin
                     state <= IDLE;
                  end else begin
                     word     <= word + IW'(1);
                     mem_read <= 1'b1;
                     mem_addr <= mem_addr + 32'd4;
                     state    <= REQ;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_result_address_readback.sv
// Bench for result_address_readback: cycle table for one record, directed corner cases,
// and randomized traffic checked against a queue of expected record words.
module tb_result_address_readback;
   localparam int          NS  = 4;
   localparam int          WPR = 4;
   localparam int          PW  = $clog2(NS + 1);
   localparam logic [31:0] STR = 32'h0000_060E;

   logic          clk;
   logic          n_rst;
   logic          record_written;
   logic          mem_read;
   logic [31:0]   mem_addr;
   logic [31:0]   mem_rdata;
   logic          mem_rvalid;
   logic [31:0]   out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic [PW-1:0] pending;
   logic          overflow;

   result_address_readback #(
      .STRIDE           (STR),
      .WORDS_PER_RECORD (WPR),
      .NUM_SLOTS        (NS)
   ) dut (
      .clk            (clk),
      .n_rst          (n_rst),
      .record_written (record_written),
      .mem_read       (mem_read),
      .mem_addr       (mem_addr),
      .mem_rdata      (mem_rdata),
      .mem_rvalid     (mem_rvalid),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_last       (out_last),
      .pending        (pending),
      .overflow       (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        last;
   } word_t;

   typedef struct {
      logic        rw;
      logic        rv;
      logic        rdy;
      logic [31:0] rdata;
      logic        e_mr;
      logic [31:0] e_addr;
      logic        e_ov;
      logic [31:0] e_data;
      logic        e_last;
      int          e_pend;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   word_t       q[$];
   int          m_pend;
   logic        m_ovf;
   int          rec_cnt;
   logic [31:0] salt;
   int          lat_mode;
   int          cur_lat;
   int          wait_cnt;
   bit          spurious_en;
   logic        prev_ov, prev_rdy, prev_mr, prev_rv;
   logic [31:0] prev_data, prev_addr;
   vec_t        tbl[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] slot_addr(input int k);
      return STR * 32'((k % NS) + 1);
   endfunction

   function automatic int pick_lat();
      return (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
   endfunction

   task automatic set_lat(input int mode);
      lat_mode = mode;
      cur_lat  = pick_lat();
      wait_cnt = 0;
   endtask

   task automatic model_clear();
      q.delete();
      m_pend    = 0;
      m_ovf     = 1'b0;
      wait_cnt  = 0;
      prev_ov   = 1'b0;
      prev_rdy  = 1'b0;
      prev_mr   = 1'b0;
      prev_rv   = 1'b0;
      prev_data = '0;
      prev_addr = '0;
   endtask

   // Holds reset for n edges, checks every output is cleared, then releases.
   task automatic do_reset(input int n);
      n_rst          = 1'b0;
      record_written = 1'b0;
      out_ready      = 1'b0;
      mem_rvalid     = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      chk("rst_mem_read", mem_read, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_pending", pending, 32'h0);
      chk("rst_overflow", overflow, 1'b0);
      n_rst = 1'b1;
      model_clear();
      rec_cnt = 0;
      cur_lat = pick_lat();
   endtask

   // One clock: drive inputs, act as memory, score handshakes, check counters.
   task automatic tick(input logic rw, input logic rdy);
      logic  dec;
      word_t wd;
      record_written = rw;
      out_ready      = rdy;
      @(negedge clk);
      if (prev_ov && !prev_rdy) begin
         chk("out_valid_hold", out_valid, 1'b1);
         chk("out_data_hold", out_data, prev_data);
      end
      if (prev_mr && !prev_rv) begin
         chk("mem_read_hold", mem_read, 1'b1);
         chk("mem_addr_hold", mem_addr, prev_addr);
      end
      if (mem_read) begin
         if (wait_cnt >= cur_lat) begin
            mem_rvalid = 1'b1;
            if (q.size() == 0) begin
               chk("read_without_record", mem_read, 1'b0);
               mem_rdata = $urandom;
            end else begin
               chk("mem_addr", mem_addr, q[0].addr);
               mem_rdata = q[0].addr ^ salt;
            end
            wait_cnt = 0;
            cur_lat  = pick_lat();
         end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            wait_cnt++;
         end
      end else begin
         mem_rvalid = spurious_en && ($urandom_range(0, 3) == 0);
         mem_rdata  = $urandom;
      end
      dec = 1'b0;
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("out_without_record", out_valid, 1'b0);
         end else begin
            chk("out_data", out_data, q[0].addr ^ salt);
            chk("out_last", out_last, q[0].last);
            dec = q[0].last;
            void'(q.pop_front());
         end
      end
      if (rw) begin
         if (m_pend == NS && !dec) begin
            m_ovf = 1'b1;
         end else begin
            for (int w = 0; w < WPR; w++) begin
               wd.addr = slot_addr(rec_cnt) + 32'(4 * w);
               wd.last = (w == WPR - 1);
               q.push_back(wd);
            end
            rec_cnt++;
            if (!dec) m_pend++;
         end
      end else if (dec) begin
         m_pend--;
      end
      prev_ov   = out_valid;
      prev_rdy  = out_ready;
      prev_data = out_data;
      prev_mr   = mem_read;
      prev_rv   = mem_rvalid;
      prev_addr = mem_addr;
      @(posedge clk);
      #1;
      record_written = 1'b0;
      chk("pending", pending, 32'(m_pend));
      chk("overflow", overflow, m_ovf);
   endtask

   task automatic wait_req(input string name);
      for (int i = 0; i < 40 && !mem_read; i++) tick(1'b0, 1'b1);
      chk(name, mem_read, 1'b1);
   endtask

   task automatic drain(input string name, input int budget);
      for (int i = 0; i < budget && q.size() != 0; i++) tick(1'b0, 1'b1);
      chk(name, pending, 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      n_rst          = 1'b0;
      record_written = 1'b0;
      out_ready      = 1'b0;
      mem_rvalid     = 1'b0;
      mem_rdata      = '0;
      salt           = '0;
      spurious_en    = 1'b0;
      lat_mode       = 0;
      cur_lat        = 0;
      rec_cnt        = 0;
      model_clear();

      // rw rv rdy rdata | mem_read mem_addr out_valid out_data out_last pending
      tbl[0]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 1};
      tbl[1]  = '{1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h060E, 1'b0, 32'h0,      1'b0, 1};
      tbl[2]  = '{1'b0, 1'b1, 1'b1, 32'h0000_060E, 1'b0, 32'h0,      1'b1, 32'h060E, 1'b0, 1};
      tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'hBAD0_0001, 1'b1, 32'h0612, 1'b0, 32'h0,      1'b0, 1};
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0612, 1'b0, 32'h0,      1'b1, 32'h0612, 1'b0, 1};
      tbl[5]  = '{1'b0, 1'b1, 1'b1, 32'hBAD0_0002, 1'b1, 32'h0616, 1'b0, 32'h0,      1'b0, 1};
      tbl[6]  = '{1'b0, 1'b1, 1'b1, 32'h0000_0616, 1'b0, 32'h0,      1'b1, 32'h0616, 1'b0, 1};
      tbl[7]  = '{1'b0, 1'b1, 1'b1, 32'hBAD0_0003, 1'b1, 32'h061A, 1'b0, 32'h0,      1'b0, 1};
      tbl[8]  = '{1'b0, 1'b1, 1'b1, 32'h0000_061A, 1'b0, 32'h0,      1'b1, 32'h061A, 1'b1, 1};
      tbl[9]  = '{1'b0, 1'b1, 1'b1, 32'hBAD0_0004, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 0};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0,      1'b0, 32'h0,      1'b0, 0};

      do_reset(2);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk("idle_mem_read", mem_read, 1'b0);
      end

      for (int i = 0; i < 11; i++) begin
         record_written = tbl[i].rw;
         mem_rvalid     = tbl[i].rv;
         out_ready      = tbl[i].rdy;
         mem_rdata      = tbl[i].rdata;
         @(posedge clk);
         #1;
         chk($sformatf("tbl%0d_mem_read", i), mem_read, tbl[i].e_mr);
         chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
         chk($sformatf("tbl%0d_out_last", i), out_last, tbl[i].e_last);
         chk($sformatf("tbl%0d_pending", i), pending, 32'(tbl[i].e_pend));
         if (tbl[i].e_mr) chk($sformatf("tbl%0d_mem_addr", i), mem_addr, tbl[i].e_addr);
         if (tbl[i].e_ov) chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].e_data);
      end
      record_written = 1'b0;
      mem_rvalid     = 1'b0;

      // Three back-to-back records with a 5-cycle host stall on the second word.
      salt = 32'h5A5A_0000;
      do_reset(1);
      set_lat(0);
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b1);
      tick(1'b1, 1'b1);
      for (int i = 0; i < 40 && !(out_valid && q.size() <= 11); i++) tick(1'b0, 1'b1);
      chk("stall_start_valid", out_valid, 1'b1);
      repeat (5) tick(1'b0, 1'b0);
      chk("stall_end_valid", out_valid, 1'b1);
      drain("three_drain_pending", 200);

      // New record lands on the same edge as a last-word handshake.
      tick(1'b1, 1'b1);
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 40 && !seen; i++) begin
            if (out_valid && out_last) begin
               seen = 1'b1;
               tick(1'b1, 1'b1);
               chk("coincident_pending", pending, 32'h1);
            end else begin
               tick(1'b0, 1'b1);
            end
         end
         chk("coincident_seen", 32'(seen), 32'h1);
      end
      drain("coincident_drain_pending", 100);

      // Saturation and sticky overflow.
      for (int i = 0; i < NS + 1; i++) tick(1'b1, 1'b0);
      chk("sat_pending", pending, 32'(NS));
      chk("sat_overflow", overflow, 1'b1);
      repeat (3) tick(1'b0, 1'b0);
      drain("sat_drain_pending", 200);
      chk("sat_overflow_sticky", overflow, 1'b1);
      do_reset(1);

      // NUM_SLOTS+1 records: the last one wraps back to the first slot.
      for (int r = 0; r < NS + 1; r++) begin
         tick(1'b1, 1'b1);
         wait_req("wrap_req_seen");
         if (r == NS) chk("wrap_addr", mem_addr, 32'h0000_060E);
         drain("wrap_drain_pending", 60);
      end

      // Slow memory, then reset while the read is still outstanding.
      set_lat(3);
      tick(1'b1, 1'b1);
      wait_req("slow_req_seen");
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      chk("slow_still_waiting", mem_read, 1'b1);
      do_reset(1);
      set_lat(0);
      tick(1'b1, 1'b1);
      wait_req("post_reset_req_seen");
      chk("post_reset_addr", mem_addr, 32'h0000_060E);
      drain("post_reset_drain_pending", 60);

      // Randomized traffic: variable latency, host stalls, stray mem_rvalid.
      salt        = $urandom;
      spurious_en = 1'b1;
      set_lat(-1);
      for (int i = 0; i < 800; i++)
         tick($urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
      spurious_en = 1'b0;
      drain("random_drain_pending", 600);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
